control_unit: RTL

- Hardwired Moore control sequencer sitting directly upstream of `datapath`; replaces bench-driven control strobes.
- Steps fetch (T0–T2) and execute (T3–T6) for register-format instructions: binary ALU, unary ALU, mul/div, nop, halt.
- Reads the IR value held in the datapath.
- Drives every datapath strobe plus register-select lines (Gra/Grb/Grc + Rin/Rout) for the datapath's select-and-encode logic.

---
 rtl/control_unit.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/control_unit.sv
// Hardwired Moore control sequencer for the register-format datapath.
// Steps fetch (T0-T2) and execute (T3-T6) and drives every datapath strobe.
module control_unit #(
    parameter int OPW = 5,
    parameter int DW  = 32
) (
    input  logic           Clock,
    input  logic           Resetn,
    input  logic [DW-1:0]  IR,
    input  logic           Stop,
    output logic           PCout,
    output logic           Zhighout,
    output logic           Zlowout,
    output logic           MDRout,
    output logic           HIout,
    output logic           LOout,
    output logic           PCin,
    output logic           IRin,
    output logic           MARin,
    output logic           MDRin,
    output logic           Yin,
    output logic           Zin,
    output logic           HIin,
    output logic           LOin,
    output logic           IncPC,
    output logic           Read,
    output logic           Gra,
    output logic           Grb,
    output logic           Grc,
    output logic           Rin,
    output logic           Rout,
    output logic [OPW-1:0] alu_op,
    output logic           Run
);

    typedef enum logic [3:0] {
        ST_RESET = 4'd0,
        ST_T0    = 4'd1,
        ST_T1    = 4'd2,
        ST_T2    = 4'd3,
        ST_T3    = 4'd4,
        ST_T4    = 4'd5,
        ST_T5    = 4'd6,
        ST_T6    = 4'd7,
        ST_HALT  = 4'd8
    } state_t;

    typedef enum logic [2:0] {
        CL_B = 3'd0,
        CL_M = 3'd1,
        CL_U = 3'd2,
        CL_N = 3'd3,
        CL_H = 3'd4
    } class_t;

    // Unlisted opcodes fall into the nop class.
    function automatic class_t classify(input logic [OPW-1:0] op);
        class_t cl;
        case (op)
            5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10: cl = CL_B;
            5'd15, 5'd16:                                     cl = CL_M;
            5'd17, 5'd18:                                     cl = CL_U;
            5'd27:                                            cl = CL_H;
            default:                                          cl = CL_N;
        endcase
        return cl;
    endfunction

    state_t         state_r;
    logic [OPW-1:0] op_s;
    class_t         class_s;
    state_t         last_next_s;
    logic           unused_ir_s;

    assign op_s        = IR[DW-1 -: OPW];
    assign class_s     = classify(op_s);
    assign unused_ir_s = ^IR[DW-OPW-1:0];
    // Stop is only honoured on the final execute step of each class.
    assign last_next_s = Stop ? ST_HALT : ST_T0;

    // State register and next-state sequencing.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_r <= ST_RESET;
        end else begin
            case (state_r)
                ST_RESET: state_r <= ST_T0;
                ST_T0:    state_r <= ST_T1;
                ST_T1:    state_r <= ST_T2;
                ST_T2:    state_r <= ST_T3;
                ST_T3: begin
                    case (class_s)
                        CL_B, CL_M, CL_U: state_r <= ST_T4;
                        CL_H:             state_r <= ST_HALT;
                        default:          state_r <= last_next_s;
                    endcase
                end
                ST_T4: begin
                    case (class_s)
                        CL_B, CL_M: state_r <= ST_T5;
                        CL_U:       state_r <= last_next_s;
                        default:    state_r <= ST_T0;
                    endcase
                end
                ST_T5: begin
                    case (class_s)
                        CL_B:    state_r <= last_next_s;
                        CL_M:    state_r <= ST_T6;
                        default: state_r <= ST_T0;
                    endcase
                end
                ST_T6:   state_r <= last_next_s;
                ST_HALT: state_r <= ST_HALT;
                default: state_r <= ST_RESET;
            endcase
        end
    end

    // Moore output decode from the state register and the IR opcode class.
    always_comb begin
        PCout    = 1'b0;
        Zhighout = 1'b0;
        Zlowout  = 1'b0;
        MDRout   = 1'b0;
        HIout    = 1'b0;
        LOout    = 1'b0;
        PCin     = 1'b0;
        IRin     = 1'b0;
        MARin    = 1'b0;
        MDRin    = 1'b0;
        Yin      = 1'b0;
        Zin      = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        IncPC    = 1'b0;
        Read     = 1'b0;
        Gra      = 1'b0;
        Grb      = 1'b0;
        Grc      = 1'b0;
        Rin      = 1'b0;
        Rout     = 1'b0;
        alu_op   = {OPW{1'b0}};
        Run      = 1'b0;
        case (state_r)
            ST_T0: begin
                Run = 1'b1; PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
            end
            ST_T1: begin
                Run = 1'b1; Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
            end
            ST_T2: begin
                Run = 1'b1; MDRout = 1'b1; IRin = 1'b1;
            end
            ST_T3: begin
                Run = 1'b1;
                case (class_s)
                    CL_B:    begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                    CL_M:    begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                    CL_U:    begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = op_s; end
                    default: begin Run = 1'b1; end
                endcase
            end
            ST_T4: begin
                Run = 1'b1;
                case (class_s)
                    CL_B:    begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = op_s; end
                    CL_M:    begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = op_s; end
                    CL_U:    begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    default: begin Run = 1'b1; end
                endcase
            end
            ST_T5: begin
                Run = 1'b1;
                case (class_s)
                    CL_B:    begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    CL_M:    begin Zlowout = 1'b1; LOin = 1'b1; end
                    default: begin Run = 1'b1; end
                endcase
            end
            ST_T6: begin
                Run = 1'b1; Zhighout = 1'b1; HIin = 1'b1;
            end
            default: begin
                Run = 1'b0;
            end
        endcase
    end

endmodule
